// File: rtl/cache_fill_arbiter_pkg.sv
// Shared constants and types for the cache fill arbiter: default geometry,
// memory latency, FSM state encoding and fill-owner encoding.
package cache_fill_arbiter_pkg;

    localparam int DEF_ADDR_W        = 16;
    localparam int DEF_DATA_W        = 16;
    localparam int DEF_WORDS_PER_BLK = 8;
    localparam int MEM_LAT           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_fill_arbiter_addr_gen.sv
// Block-fill address generator: latches the missing block's tag bits and
// walks the word offset, one memory request per cycle while issuing.
module cache_fill_arbiter_addr_gen
    import cache_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_load,
    input  logic [ADDR_W-$clog2(WORDS_PER_BLK)-2:0]   i_tag,
    input  logic                                      i_issue,
    output logic                                      o_mem_en,
    output logic [ADDR_W-1:0]                         o_mem_addr,
    output logic                                      o_last_issue
);
    localparam int OFF_W = $clog2(WORDS_PER_BLK);
    localparam int TAG_W = ADDR_W - OFF_W - 1;

    logic [TAG_W-1:0] r_tag_base;
    logic [OFF_W-1:0] r_issue_cnt;

    // The offset counter is only OFF_W wide, so addresses wrap within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_base  <= '0;
            r_issue_cnt <= '0;
        end else if (i_load) begin
            r_tag_base  <= i_tag;
            r_issue_cnt <= '0;
        end else if (i_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign o_mem_en     = i_issue;
    assign o_mem_addr   = i_issue ? {r_tag_base, r_issue_cnt, 1'b0} : '0;
    assign o_last_issue = i_issue && (r_issue_cnt == {OFF_W{1'b1}});

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory port between I-cache and D-cache misses,
// sequencing each block fill and driving the per-cache stall signals.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_icache_miss,
    input  logic [ADDR_W-1:0]                i_icache_miss_addr,
    input  logic                             i_dcache_miss,
    input  logic [ADDR_W-1:0]                i_dcache_miss_addr,
    output logic                             o_mem_en,
    output logic [ADDR_W-1:0]                o_mem_addr,
    input  logic [DATA_W-1:0]                i_mem_data_in,
    input  logic                             i_mem_data_valid,
    output logic [DATA_W-1:0]                o_fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] o_fill_word_idx,
    output logic                             o_icache_data_we,
    output logic                             o_dcache_data_we,
    output logic                             o_icache_tag_we,
    output logic                             o_dcache_tag_we,
    output logic                             o_icache_stall,
    output logic                             o_dcache_stall,
    output logic                             o_fill_busy
);
    localparam int OFF_W = $clog2(WORDS_PER_BLK);
    localparam int BLK_W = OFF_W + 1;
    localparam int TAG_W = ADDR_W - BLK_W;

    fill_state_t      r_state;
    fill_state_t      w_next_state;
    owner_t           r_owner;
    logic [OFF_W:0]   r_recv_cnt;
    logic             w_start;
    logic             w_issue;
    logic             w_last_issue;
    logic             w_write;
    logic             w_last_word;
    logic [TAG_W-1:0] w_sel_tag;
    logic             w_unused_lsbs;

    // D-miss wins a tie: it belongs to the older instruction in the pipeline.
    assign w_start   = (r_state == ST_IDLE) && (i_icache_miss || i_dcache_miss);
    assign w_issue   = (r_state == ST_FILL);
    assign w_sel_tag = i_dcache_miss ? i_dcache_miss_addr[ADDR_W-1:BLK_W]
                                     : i_icache_miss_addr[ADDR_W-1:BLK_W];
    assign w_unused_lsbs = ^{i_icache_miss_addr[BLK_W-1:0], i_dcache_miss_addr[BLK_W-1:0]};

    assign w_write     = i_mem_data_valid && !r_recv_cnt[OFF_W] &&
                         ((r_state == ST_FILL) || (r_state == ST_DRAIN));
    assign w_last_word = w_write && (r_recv_cnt[OFF_W-1:0] == {OFF_W{1'b1}});

    cache_fill_arbiter_addr_gen #(
        .ADDR_W        (ADDR_W),
        .WORDS_PER_BLK (WORDS_PER_BLK)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_start),
        .i_tag        (w_sel_tag),
        .i_issue      (w_issue),
        .o_mem_en     (o_mem_en),
        .o_mem_addr   (o_mem_addr),
        .o_last_issue (w_last_issue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner is frozen at acceptance; later miss-level changes cannot abort a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWNER_I;
            r_recv_cnt <= '0;
        end else if (w_start) begin
            r_owner    <= i_dcache_miss ? OWNER_D : OWNER_I;
            r_recv_cnt <= '0;
        end else if (w_write) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        o_icache_data_we = 1'b0;
        o_dcache_data_we = 1'b0;
        o_icache_tag_we  = 1'b0;
        o_dcache_tag_we  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start)      w_next_state = ST_FILL;
            ST_FILL:  if (w_last_issue) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_last_word)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        o_icache_data_we = w_write && (r_owner == OWNER_I);
        o_dcache_data_we = w_write && (r_owner == OWNER_D);
        o_icache_tag_we  = (r_state == ST_DONE) && (r_owner == OWNER_I);
        o_dcache_tag_we  = (r_state == ST_DONE) && (r_owner == OWNER_D);
    end

    assign o_fill_data     = i_mem_data_in;
    assign o_fill_word_idx = r_recv_cnt[OFF_W-1:0];
    assign o_icache_stall  = i_icache_miss && !o_icache_tag_we;
    assign o_dcache_stall  = i_dcache_miss && !o_dcache_tag_we;
    assign o_fill_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: stimulus queues expected memory
// requests, fill writes and tag pulses; a negedge monitor pops and compares.
module tb_cache_fill_arbiter;
    import cache_fill_arbiter_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } addrExp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic [2:0]  idx;
        logic [15:0] data;
    } wrExp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
    } tagExp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } memReq_t;

    logic        clk;
    logic        rst_n;
    logic        iMiss;
    logic [15:0] iAddr;
    logic        dMiss;
    logic [15:0] dAddr;
    logic        o_mem_en;
    logic [15:0] o_mem_addr;
    logic [15:0] memData;
    logic        memValid;
    logic [15:0] o_fill_data;
    logic [2:0]  o_fill_word_idx;
    logic        o_icache_data_we;
    logic        o_dcache_data_we;
    logic        o_icache_tag_we;
    logic        o_dcache_tag_we;
    logic        o_icache_stall;
    logic        o_dcache_stall;
    logic        o_fill_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int memLat;
    int spurA;
    int spurB;
    int t0;

    addrExp_t addrQ[$];
    wrExp_t   wrQ[$];
    tagExp_t  tagQ[$];
    memReq_t  memQ[$];

    cache_fill_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_icache_miss      (iMiss),
        .i_icache_miss_addr (iAddr),
        .i_dcache_miss      (dMiss),
        .i_dcache_miss_addr (dAddr),
        .o_mem_en           (o_mem_en),
        .o_mem_addr         (o_mem_addr),
        .i_mem_data_in      (memData),
        .i_mem_data_valid   (memValid),
        .o_fill_data        (o_fill_data),
        .o_fill_word_idx    (o_fill_word_idx),
        .o_icache_data_we   (o_icache_data_we),
        .o_dcache_data_we   (o_dcache_data_we),
        .o_icache_tag_we    (o_icache_tag_we),
        .o_dcache_tag_we    (o_dcache_tag_we),
        .o_icache_stall     (o_icache_stall),
        .o_dcache_stall     (o_dcache_stall),
        .o_fill_busy        (o_fill_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [26:0] outVec();
        return {o_mem_en, o_mem_addr, o_fill_word_idx, o_icache_data_we, o_dcache_data_we,
                o_icache_tag_we, o_dcache_tag_we, o_icache_stall, o_dcache_stall, o_fill_busy};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagUnexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: unexpected event in cycle %0d", name, cyc);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic setI, input logic [15:0] ia,
                                 input logic setD, input logic [15:0] da);
        iMiss = setI;
        iAddr = ia;
        dMiss = setD;
        dAddr = da;
    endtask

    // Expected events for one complete fill whose miss is accepted in cycle start.
    task automatic pushFill(input logic isD, input logic [15:0] missAddr,
                            input int start, input int lat);
        addrExp_t    ae;
        wrExp_t      we;
        tagExp_t     te;
        logic [15:0] base;
        logic [15:0] a;
        base = {missAddr[15:4], 4'h0};
        for (int k = 0; k < 8; k++) begin
            a        = base + 16'(2 * k);
            ae.cyc   = start + 1 + k;
            ae.addr  = a;
            addrQ.push_back(ae);
            we.cyc   = start + 1 + lat + k;
            we.sel   = isD ? 2'b01 : 2'b10;
            we.idx   = 3'(k);
            we.data  = memWord(a);
            wrQ.push_back(we);
        end
        te.cyc = start + lat + 9;
        te.sel = isD ? 2'b01 : 2'b10;
        tagQ.push_back(te);
    endtask

    task automatic waitTag(input logic isD, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (isD ? o_dcache_tag_we : o_icache_tag_we) seen = 1'b1;
        end
        if (!seen) flagUnexpected(isD ? "dtag_timeout" : "itag_timeout");
    endtask

    task automatic finishTest();
        repeat (4) @(negedge clk);
        checkOutput("addr_q_drained", 32'(addrQ.size()), 32'd0);
        checkOutput("wr_q_drained",   32'(wrQ.size()),   32'd0);
        checkOutput("tag_q_drained",  32'(tagQ.size()),  32'd0);
        checkOutput("idle_after",     {31'd0, o_fill_busy}, 32'd0);
    endtask

    // Pipelined memory: a request seen in cycle c returns data in cycle c+memLat.
    always @(negedge clk) begin
        memReq_t r;
        if (o_mem_en) begin
            r.due  = cyc + memLat;
            r.addr = o_mem_addr;
            memQ.push_back(r);
        end
    end

    always @(posedge clk) begin
        #1;
        if (memQ.size() > 0 && memQ[0].due == cyc) begin
            memValid = 1'b1;
            memData  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end else if (cyc == spurA || cyc == spurB) begin
            memValid = 1'b1;
            memData  = 16'hDEAD;
        end else begin
            memValid = 1'b0;
            memData  = 16'h0000;
        end
    end

    always @(negedge clk) begin
        addrExp_t ae;
        wrExp_t   we;
        tagExp_t  te;
        if (o_mem_en) begin
            if (addrQ.size() == 0) begin
                flagUnexpected("extra_mem_en");
            end else begin
                ae = addrQ.pop_front();
                checkOutput("mem_cycle", 32'(cyc), 32'(ae.cyc));
                checkOutput("mem_addr",  {16'd0, o_mem_addr}, {16'd0, ae.addr});
            end
        end
        if (o_icache_data_we || o_dcache_data_we) begin
            if (wrQ.size() == 0) begin
                flagUnexpected("extra_data_we");
            end else begin
                we = wrQ.pop_front();
                checkOutput("wr_cycle", 32'(cyc), 32'(we.cyc));
                checkOutput("wr_sel",   {30'd0, o_icache_data_we, o_dcache_data_we}, {30'd0, we.sel});
                checkOutput("wr_idx",   {29'd0, o_fill_word_idx}, {29'd0, we.idx});
                checkOutput("wr_data",  {16'd0, o_fill_data}, {16'd0, we.data});
            end
        end
        if (o_icache_tag_we || o_dcache_tag_we) begin
            if (tagQ.size() == 0) begin
                flagUnexpected("extra_tag_we");
            end else begin
                te = tagQ.pop_front();
                checkOutput("tag_cycle", 32'(cyc), 32'(te.cyc));
                checkOutput("tag_sel",   {30'd0, o_icache_tag_we, o_dcache_tag_we}, {30'd0, te.sel});
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addrExp_t ae;
        wrExp_t   we;
        logic [15:0] a;
        rst_n    = 1'b0;
        memLat   = MEM_LAT;
        spurA    = -1;
        spurB    = -1;
        memValid = 1'b0;
        memData  = 16'h0000;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {5'd0, outVec()}, 32'd0);
        nextCycle();
        rst_n = 1'b1;
        repeat (2) nextCycle();

        // Lone I-miss at 0x1236.
        t0 = cyc;
        pushFill(1'b0, 16'h1236, t0, memLat);
        applyStimulus(1'b1, 16'h1236, 1'b0, 16'h0000);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("istall_mid_fill", {31'd0, o_icache_stall}, 32'd1);
        checkOutput("busy_mid_fill",   {31'd0, o_fill_busy},    32'd1);
        waitTag(1'b0, 40);
        checkOutput("istall_at_done", {31'd0, o_icache_stall}, 32'd0);
        nextCycle();
        iMiss = 1'b0;
        finishTest();

        // Simultaneous misses: D block 0x8000 first, then I block 0x0040.
        nextCycle();
        t0 = cyc;
        pushFill(1'b1, 16'h8002, t0, memLat);
        pushFill(1'b0, 16'h0040, t0 + 14, memLat);
        applyStimulus(1'b1, 16'h0040, 1'b1, 16'h8002);
        waitTag(1'b1, 40);
        checkOutput("istall_during_d", {31'd0, o_icache_stall}, 32'd1);
        checkOutput("dstall_at_done",  {31'd0, o_dcache_stall}, 32'd0);
        nextCycle();
        dMiss = 1'b0;
        waitTag(1'b0, 40);
        checkOutput("istall_at_done2", {31'd0, o_icache_stall}, 32'd0);
        nextCycle();
        iMiss = 1'b0;
        finishTest();

        // I-miss withdrawn in cycle 3 of its fill.
        nextCycle();
        t0 = cyc;
        pushFill(1'b0, 16'h2468, t0, memLat);
        applyStimulus(1'b1, 16'h2468, 1'b0, 16'h0000);
        repeat (3) nextCycle();
        iMiss = 1'b0;
        waitTag(1'b0, 40);
        checkOutput("istall_withdrawn", {31'd0, o_icache_stall}, 32'd0);
        finishTest();

        // Spurious valid in IDLE, then a 9th word during DONE.
        nextCycle();
        spurA = cyc + 2;
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("idle_after_spur", {31'd0, o_fill_busy}, 32'd0);
        nextCycle();
        t0 = cyc;
        pushFill(1'b0, 16'h3000, t0, memLat);
        spurB = t0 + 13;
        applyStimulus(1'b1, 16'h3000, 1'b0, 16'h0000);
        waitTag(1'b0, 40);
        nextCycle();
        iMiss = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_9th", {31'd0, o_fill_busy}, 32'd0);
        finishTest();

        // Reset in cycle 7 of a D fill: only words 0-1 written, no tag.
        nextCycle();
        t0 = cyc;
        for (int k = 0; k < 6; k++) begin
            a       = 16'h4A10 + 16'(2 * k);
            ae.cyc  = t0 + 1 + k;
            ae.addr = a;
            addrQ.push_back(ae);
            if (k < 2) begin
                we.cyc  = t0 + 1 + memLat + k;
                we.sel  = 2'b01;
                we.idx  = 3'(k);
                we.data = memWord(a);
                wrQ.push_back(we);
            end
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h4A10);
        repeat (7) nextCycle();
        rst_n = 1'b0;
        dMiss = 1'b0;
        @(negedge clk);
        checkOutput("outputs_in_reset", {5'd0, outVec()}, 32'd0);
        repeat (2) nextCycle();
        rst_n = 1'b1;
        repeat (4) nextCycle();
        checkOutput("idle_after_reset", {31'd0, o_fill_busy}, 32'd0);
        checkOutput("partial_wr_drained", 32'(wrQ.size()), 32'd0);
        t0 = cyc;
        pushFill(1'b1, 16'h4A10, t0, memLat);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h4A10);
        waitTag(1'b1, 40);
        checkOutput("dstall_refill_done", {31'd0, o_dcache_stall}, 32'd0);
        nextCycle();
        dMiss = 1'b0;
        finishTest();

        // Slower memory: six-cycle latency.
        memLat = 6;
        nextCycle();
        t0 = cyc;
        pushFill(1'b0, 16'h0F0E, t0, memLat);
        applyStimulus(1'b1, 16'h0F0E, 1'b0, 16'h0000);
        waitTag(1'b0, 40);
        checkOutput("istall_lat6_done", {31'd0, o_icache_stall}, 32'd0);
        nextCycle();
        iMiss = 1'b0;
        finishTest();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
